fxp_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one signed Q8.7 fixed-point multiplier among NREQ requesters, e.g. the ODE stage evaluators.
- Accepts at most one operand pair per cycle through a two-stage pipeline with output backpressure.
- Returns each product tagged with its requester ID and an overflow flag.
- Keeps a saturating count of overflow events for debug.

---
 rtl/fxp_mult_arbiter_if.sv | 35 +++
 rtl/fxp_mult_arbiter.sv | 174 +++++++++++++++++
 tb/tb_fxp_mult_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mult_arbiter_if
// Purpose  : Groups the request and response handshake signals of the
//            shared Q8.7 multiplier arbiter.
// Ports    : req_valid/req_a/req_b/req_ready - per-requester operand channel
//            resp_valid/resp_ready/resp_id/resp_result/resp_ovf - result channel
// Modports : master - requester/consumer side, slave - arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface fxp_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [15:0]        resp_result;
  logic               resp_ovf;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_ovf
  );
endinterface
`default_nettype wire

// File: rtl/fxp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fxp_mult_arbiter
// Purpose  : Round-robin arbiter sharing one signed Q8.7 multiplier among
//            NREQ requesters. Two-stage pipeline (operand register, output
//            register) with output backpressure; each product carries its
//            requester id and an overflow flag. A saturating counter tracks
//            overflowed results delivered.
// Ports    : clk, rst_n (async, active low)
//            bus       - slave side of fxp_mult_arbiter_if
//            ovf_clr   - synchronous clear of ovf_count
//            ovf_count - saturating count of overflowed results delivered
// Revision : 1.0 - initial release
// ============================================================================
module fxp_mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int SATURATE = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  fxp_mult_arbiter_if.slave bus,
  input  wire logic         ovf_clr,
  output logic [15:0]       ovf_count
);

  // Pointer resets to the last requester so requester 0 is searched first.
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  logic            adv1, adv2, accept, grant_found;
  logic [IDW-1:0]  grant_idx;
  int              cand;
  logic [NREQ-1:0] req_ready_w;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [15:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [15:0]     resp_result_q, resp_result_d;
  logic            resp_ovf_q, resp_ovf_d;
  logic [15:0]     ovf_count_q, ovf_count_d;

  logic signed [31:0] a_ext, b_ext, prod, rnd;
  logic               ovf_w;
  logic [15:0]        result_w;
  logic               unused_rnd_lsb;

  assign adv2 = !resp_valid_q | bus.resp_ready;
  assign adv1 = !s1_valid_q | adv2;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant is suppressed during reset so nothing is handshaken while the
  // flops are held.
  assign accept = rst_n & adv1 & grant_found;

  always_comb begin
    req_ready_w = '0;
    if (accept) begin
      req_ready_w[grant_idx] = 1'b1;
    end
  end

  assign bus.req_ready = req_ready_w;

  // Stage 1: operand register and arbitration pointer.
  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (adv1) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      ptr_d   = grant_idx;
      s1_a_d  = bus.req_a[int'(grant_idx)*16 +: 16];
      s1_b_d  = bus.req_b[int'(grant_idx)*16 +: 16];
      s1_id_d = grant_idx;
    end
  end

  // Q8.7 x Q8.7 -> Q16.14, round half-up at bit 6, keep bits [22:7].
  assign a_ext = {{16{s1_a_q[15]}}, s1_a_q};
  assign b_ext = {{16{s1_b_q[15]}}, s1_b_q};
  assign prod  = a_ext * b_ext;
  assign rnd   = prod + 32'sd64;

  // Result fits in 16 bits only when bits [31:22] are a pure sign extension.
  assign ovf_w          = ~((&rnd[31:22]) | ~(|rnd[31:22]));
  assign unused_rnd_lsb = ^rnd[6:0];

  generate
    if (SATURATE != 0) begin : g_sat
      assign result_w = ovf_w ? (rnd[31] ? 16'h8000 : 16'h7FFF) : rnd[22:7];
    end else begin : g_trunc
      assign result_w = rnd[22:7];
    end
  endgenerate

  // Stage 2: output register, held stable while stalled.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_ovf_d    = resp_ovf_q;
    if (adv2) begin
      resp_valid_d  = s1_valid_q;
      resp_id_d     = s1_id_q;
      resp_result_d = result_w;
      resp_ovf_d    = ovf_w;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = '0;
    end else if (resp_valid_q && bus.resp_ready && resp_ovf_q &&
                 (ovf_count_q != 16'hFFFF)) begin
      ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= PTR_RST;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_id_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_ovf_q    <= 1'b0;
      ovf_count_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_id_q       <= s1_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_ovf_q    <= resp_ovf_d;
      ovf_count_q   <= ovf_count_d;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_ovf    = resp_ovf_q;
  assign ovf_count       = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_mult_arbiter
// Purpose  : Directed self-checking bench for fxp_mult_arbiter. Two instances
//            (truncating and saturating) receive identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fxp_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               resp_ready;
  logic               ovf_clr;
  logic [15:0]        ovf_count0, ovf_count1;

  int n_pass  = 0;
  int n_total = 0;
  int exp_g [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

  always #5 clk = ~clk;

  fxp_mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus0 ();
  fxp_mult_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus1 ();

  assign bus0.req_valid  = req_valid;
  assign bus0.req_a      = req_a;
  assign bus0.req_b      = req_b;
  assign bus0.resp_ready = resp_ready;
  assign bus1.req_valid  = req_valid;
  assign bus1.req_a      = req_a;
  assign bus1.req_b      = req_b;
  assign bus1.resp_ready = resp_ready;

  fxp_mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .SATURATE(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count0)
  );

  fxp_mult_arbiter #(.NREQ(NREQ), .IDW(IDW), .SATURATE(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [31:0] exp);
    chk({tag, " ready0"}, 32'(bus0.req_ready), exp);
    chk({tag, " ready1"}, 32'(bus1.req_ready), exp);
  endtask

  // v=0 only checks that no response is presented.
  task automatic chk_resp(input string tag, input logic v, input logic [31:0] id,
                          input logic [31:0] r0, input logic [31:0] r1, input logic o);
    chk({tag, " valid0"}, 32'(bus0.resp_valid), 32'(v));
    chk({tag, " valid1"}, 32'(bus1.resp_valid), 32'(v));
    if (v) begin
      chk({tag, " id0"},     32'(bus0.resp_id),     id);
      chk({tag, " id1"},     32'(bus1.resp_id),     id);
      chk({tag, " result0"}, 32'(bus0.resp_result), r0);
      chk({tag, " result1"}, 32'(bus1.resp_result), r1);
      chk({tag, " ovf0"},    32'(bus0.resp_ovf),    32'(o));
      chk({tag, " ovf1"},    32'(bus1.resp_ovf),    32'(o));
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    chk({tag, " cnt0"}, 32'(ovf_count0), exp);
    chk({tag, " cnt1"}, 32'(ovf_count1), exp);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
  endtask

  // Requester i multiplies (i+1).0 by 2.0 -> result 16'h0100*(i+1).
  task automatic load_rr();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'(16'h0080 * (i + 1));
      req_b[16*i +: 16] = 16'h0100;
    end
  endtask

  // One isolated transaction with resp_ready=1; the response is checked and
  // then consumed.
  task automatic single(input string tag, input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] e0,
                        input logic [15:0] e1, input logic eo);
    req_valid         = '0;
    req_valid[id]     = 1'b1;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    #1;
    chk_grant(tag, 32'(1) << id);
    tick();
    req_valid = '0;
    chk_resp({tag, " s1"}, 1'b0, 0, 0, 0, 1'b0);
    tick();
    chk_resp(tag, 1'b1, 32'(id), 32'(e0), 32'(e1), eo);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    ovf_clr    = 1'b0;

    // Reset state, including req_ready held low while requests are pending.
    #2 req_valid = 4'hF;
    #1;
    chk_grant("rst", 0);
    chk_resp("rst", 1'b0, 0, 0, 0, 1'b0);
    chk("rst id0",     32'(bus0.resp_id), 0);
    chk("rst result0", 32'(bus0.resp_result), 0);
    chk("rst ovf0",    32'(bus0.resp_ovf), 0);
    chk_cnt("rst", 0);
    req_valid = '0;
    #6 rst_n = 1'b1;
    tick();

    // Single request from requester 2: 2.0 * 1.5 = 3.0.
    single("single", 2, 16'h0100, 16'h00C0, 16'h0180, 16'h0180, 1'b0);
    chk_resp("single drain", 1'b0, 0, 0, 0, 1'b0);

    // Round-robin fairness, requester 1 dropped after eight grants.
    do_reset();
    load_rr();
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'hD;
      #1;
      chk_grant("rr grant", 32'(1) << exp_g[c]);
      tick();
      if (c > 0) begin
        chk_resp("rr resp", 1'b1, 32'(exp_g[c-1]), 32'(256 * (exp_g[c-1] + 1)),
                 32'(256 * (exp_g[c-1] + 1)), 1'b0);
      end
    end
    req_valid = '0;
    tick();
    chk_resp("rr last", 1'b1, 0, 32'h0100, 32'h0100, 1'b0);
    tick();
    chk_resp("rr idle", 1'b0, 0, 0, 0, 1'b0);

    // Rounding, sign and overflow.
    single("neg round", 1, 16'hFF80, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
    single("half up",   3, 16'h0001, 16'h0040, 16'h0001, 16'h0001, 1'b0);
    single("neg x neg", 0, 16'hFF80, 16'hFF80, 16'h0080, 16'h0080, 1'b0);
    chk_cnt("no ovf", 0);
    single("ovf pos",   2, 16'h4000, 16'h4000, 16'h0000, 16'h7FFF, 1'b1);
    chk_cnt("ovf pos", 1);
    single("ovf neg",   1, 16'h4000, 16'hC000, 16'h0000, 16'h8000, 1'b1);
    chk_cnt("ovf neg", 2);

    // Clear coinciding with an overflowed output handshake.
    req_valid = 4'b0001;
    req_a[15:0] = 16'h4000;
    req_b[15:0] = 16'h4000;
    tick();
    req_valid = '0;
    tick();
    chk_resp("clr resp", 1'b1, 0, 32'h0000, 32'h7FFF, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk_cnt("clr", 0);

    // Backpressure: two accepted, then no grants, outputs held.
    do_reset();
    load_rr();
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    #1;
    chk_grant("bp g0", 32'b0001);
    tick();
    chk_grant("bp g1", 32'b0010);
    tick();
    chk_grant("bp full", 0);
    chk_resp("bp hold a", 1'b1, 0, 32'h0100, 32'h0100, 1'b0);
    tick();
    chk_grant("bp full2", 0);
    chk_resp("bp hold b", 1'b1, 0, 32'h0100, 32'h0100, 1'b0);
    tick();
    chk_resp("bp hold c", 1'b1, 0, 32'h0100, 32'h0100, 1'b0);
    resp_ready = 1'b1;
    #1;
    chk_grant("bp release", 32'b0100);
    tick();
    req_valid = '0;
    chk_resp("bp out1", 1'b1, 1, 32'h0200, 32'h0200, 1'b0);
    tick();
    chk_resp("bp out2", 1'b1, 2, 32'h0300, 32'h0300, 1'b0);
    tick();
    chk_resp("bp empty", 1'b0, 0, 0, 0, 1'b0);

    // Asynchronous reset with the pipeline full.
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    tick();
    tick();
    chk_resp("full", 1'b1, 3, 32'h0400, 32'h0400, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_resp("async rst", 1'b0, 0, 0, 0, 1'b0);
    chk_grant("async rst", 0);
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    chk_grant("post rst", 32'b0001);
    tick();
    req_valid = '0;
    chk_resp("post rst flush", 1'b0, 0, 0, 0, 1'b0);
    tick();
    chk_resp("post rst resp", 1'b1, 0, 32'h0100, 32'h0100, 1'b0);
    tick();
    chk_resp("post rst idle", 1'b0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
